mdu_unit: RTL
=============

# mdu_unit

Multi-cycle integer multiply/divide unit for the MIPS datapath. It takes its two operands from the register file read ports (`saidaA`/`saidaB`) and iterates one bit per cycle. It then returns the selected 32-bit result to the register file write port (`controle`/`entrada`/`wr`). It handles long-latency ops so the single-cycle ALU path stays short.

## Interface
- `WIDTH`, 32: operand and result width; iteration count equals `WIDTH`.
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low; low forces reset state immediately.
- `start`  in  1  request; sampled only when `busy`=0.
- `op`  in  2  00 MUL low word, 01 MUL high word, 10 DIV quotient, 11 DIV remainder.
- `sgn`  in  1  signed operation (honoured only with `MDU_SIGNED_EN`).
- `opA`  in  WIDTH  multiplicand / dividend (from `saidaA`).
- `opB`  in  WIDTH  multiplier / divisor (from `saidaB`).
- `dest`  in  5  destination register index.
- `busy`  out  1  high from the cycle after accept until the write-back cycle, inclusive.
- `wr`  out  1  one-cycle write strobe to the register file.
- `controle`  out  5  write index, valid while `wr`=1.
- `entrada`  out  WIDTH  write data, valid while `wr`=1; holds the last result afterwards.

## Operation
- States: IDLE, CALC, FIX (only with `MDU_SIGNED_EN`), WB.
- IDLE: `start`=1 latches `opA`, `opB`, `op`, `sgn`, `dest`, loads the 5-bit counter with WIDTH-1, and goes to CALC.
- CALC, multiply: shift-add on the 2·WIDTH product register {hi,lo}.
  - If lo[0]=1, add B to hi with carry-out kept.
  - Then shift the product register right by one.
- CALC, divide: restoring division.
  - Shift {rem,quot} left by one.
  - If rem ≥ B, subtract B and set quot[0]=1.
- CALC exit: when the counter reaches 0, go to FIX if signed, else WB. Otherwise decrement the counter.
- WB: `wr`=1, `controle`=latched `dest`, `entrada`=result selected by `op`, then go to IDLE.
- Divide by zero: no trap. Quotient is all-ones and remainder equals the dividend, which the algorithm produces naturally.
- `dest` ≥ 16: the unit still strobes `wr`; the register file discards the write.
- `start` while `busy`=1 is ignored. There is no queue and no error flag.
- Arithmetic is unsigned modulo 2^WIDTH unless the signed feature is active.

## Timing
- Reset values: `busy`=0, `wr`=0, `controle`=0, `entrada`=0, state IDLE, counter 0.
- Unsigned latency: `start` sampled at edge 0, CALC occupies edges 1..32, `wr`=1 in the cycle after edge 33.
- Signed latency: one extra cycle for FIX.
- Back-to-back: a new `start` is accepted in the cycle `wr` is high only if `busy`=0. `busy` is low in that cycle, so the next accept is the edge after WB.
- Reset asserted mid-operation: return to IDLE at once, no `wr` pulse, partial result discarded.
- Operand inputs may change freely after the accept edge.

## Configuration
- `MDU_SIGNED_EN` defined, with `sgn`=1:
  - Operands are converted to magnitudes at accept.
  - FIX negates the product if the operand signs differ.
  - FIX negates the quotient if the operand signs differ, and gives the remainder the sign of the dividend.
  - Signed divide by zero returns all-ones quotient and dividend remainder.
- `MDU_SIGNED_EN` undefined: `sgn` is ignored, FIX does not exist, and all ops are unsigned at fixed latency.

## Structure
- Package `mdu_pkg`: `op` encodings (`MDU_MULLO`, `MDU_MULHI`, `MDU_DIVQ`, `MDU_DIVR`), state enum, `MDU_ITER` = 32.
- Sub-module `mdu_step`: combinational single-iteration step, one mode each for add-shift and compare-subtract-shift. `mdu_unit` holds the FSM, counter and registers.

## Test plan
- Multiply low word: `op`=00, 7×6, `dest`=3 → `wr`=1 exactly 34 cycles after `start`, `controle`=3, `entrada`=42.
- Multiply high word: `op`=01, 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; same with `op`=00 → 0x00000001.
- Divide: `op`=10, 100÷7 → 14; `op`=11 → 2. Divide by zero, 5÷0 → quotient 0xFFFFFFFF, remainder 5.
- Start while busy: `start` pulsed on cycle 10 of an operation → ignored, exactly one `wr` pulse.
- Reset mid-operation: `reset` low at CALC cycle 15 → `busy` and `wr` at 0 immediately, no write after release, next op correct.
- Signed, with `MDU_SIGNED_EN`: −7×3 → 0xFFFFFFEB; −7÷2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; latency 35.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit.
// MDU_SIGNED_EN adds the FIX state used by signed operations.
package mdu_pkg;

  localparam int MDU_ITER = 32;

  typedef enum logic [1:0] {
    MDU_MULLO = 2'b00,
    MDU_MULHI = 2'b01,
    MDU_DIVQ  = 2'b10,
    MDU_DIVR  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_WB   = 2'd2
`ifdef MDU_SIGNED_EN
    ,
    S_FIX  = 2'd3
`endif
  } mdu_state_e;

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } mdu_mode_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mdu_unit_if.sv
// Register-file side bus of the multiply/divide unit.
// Handshake: start is sampled on a rising clock edge only while busy=0; wr is a
// one-cycle strobe with controle/entrada valid alongside it (entrada holds afterwards).
interface mdu_unit_if #(parameter int WIDTH = mdu_pkg::MDU_ITER);
  logic             start;
  logic [1:0]       op;
  logic             sgn;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [4:0]       dest;
  logic             busy;
  logic             wr;
  logic [4:0]       controle;
  logic [WIDTH-1:0] entrada;

  modport master (
    output start, op, sgn, opA, opB, dest,
    input  busy, wr, controle, entrada
  );

  modport slave (
    input  start, op, sgn, opA, opB, dest,
    output busy, wr, controle, entrada
  );
endinterface

// File: rtl/mdu_step.sv
// One iteration of the datapath: shift-add for multiply, restoring
// compare-subtract-shift for divide. {hi,lo} is {product} or {remainder,quotient}.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_ITER
) (
  input  mdu_mode_e        mode,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic           ge;

  always_comb begin
    sum    = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
    rem_sh = {hi, lo[WIDTH-1]};
    ge     = (rem_sh >= {1'b0, b});
    hi_nxt = sum[WIDTH:1];
    lo_nxt = {sum[0], lo[WIDTH-1:1]};
    if (mode == STEP_DIV) begin
      // A true difference always fits in WIDTH bits, so the modular subtract is exact.
      hi_nxt = ge ? (rem_sh[WIDTH-1:0] - b) : rem_sh[WIDTH-1:0];
      lo_nxt = {lo[WIDTH-2:0], ge};
    end
  end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle integer multiply/divide unit, one bit per cycle, result written back
// through a one-cycle register-file strobe. Define MDU_SIGNED_EN for signed ops.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_ITER
) (
  input  logic        clock,
  input  logic        reset,
  mdu_unit_if.slave   bus,
  output mdu_state_e  dbg_state
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q, b_q;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] result;
  mdu_op_e          op_q;
  logic [4:0]       dest_q;
  logic             wr_q;
  logic [4:0]       controle_q;
  logic [WIDTH-1:0] entrada_q;
  mdu_mode_e        mode;

`ifdef MDU_SIGNED_EN
  logic sgn_q, neg_a_q, neg_b_q;
  logic neg_a, neg_b;

  assign neg_a = bus.sgn & bus.opA[WIDTH-1];
  assign neg_b = bus.sgn & bus.opB[WIDTH-1];
  assign a_mag = neg_a ? (~bus.opA + 1'b1) : bus.opA;
  assign b_mag = neg_b ? (~bus.opB + 1'b1) : bus.opB;
`else
  logic sgn_unused;

  assign sgn_unused = bus.sgn;
  assign a_mag      = bus.opA;
  assign b_mag      = bus.opB;
`endif

  assign mode = op_is_div(op_q) ? STEP_DIV : STEP_MUL;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .mode   (mode),
    .hi     (hi_q),
    .lo     (lo_q),
    .b      (b_q),
    .hi_nxt (hi_nxt),
    .lo_nxt (lo_nxt)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.start) state_d = S_CALC;
      S_CALC: begin
        if (cnt_q == '0) begin
`ifdef MDU_SIGNED_EN
          state_d = sgn_q ? S_FIX : S_WB;
`else
          state_d = S_WB;
`endif
        end
      end
`ifdef MDU_SIGNED_EN
      S_FIX:  state_d = S_WB;
`endif
      S_WB:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      b_q    <= '0;
      op_q   <= MDU_MULLO;
      dest_q <= '0;
`ifdef MDU_SIGNED_EN
      sgn_q   <= 1'b0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            hi_q   <= '0;
            lo_q   <= a_mag;
            b_q    <= b_mag;
            op_q   <= mdu_op_e'(bus.op);
            dest_q <= bus.dest;
            cnt_q  <= CW'(WIDTH - 1);
`ifdef MDU_SIGNED_EN
            sgn_q   <= bus.sgn;
            neg_a_q <= neg_a;
            neg_b_q <= neg_b;
`endif
          end
        end
        S_CALC: begin
          hi_q <= hi_nxt;
          lo_q <= lo_nxt;
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
`ifdef MDU_SIGNED_EN
        S_FIX: begin
          if (!op_is_div(op_q)) begin
            if (neg_a_q ^ neg_b_q) {hi_q, lo_q} <= ~{hi_q, lo_q} + 1'b1;
          end else begin
            // Divide by zero keeps the all-ones quotient; remainder follows the dividend.
            if ((neg_a_q ^ neg_b_q) && (b_q != '0)) lo_q <= ~lo_q + 1'b1;
            if (neg_a_q) hi_q <= ~hi_q + 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    case (op_q)
      MDU_MULLO, MDU_DIVQ: result = lo_q;
      default:             result = hi_q;
    endcase
  end

  // Write-back is registered out of WB, so the strobe appears with busy already low.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_q       <= 1'b0;
      controle_q <= '0;
      entrada_q  <= '0;
    end else begin
      wr_q <= (state_q == S_WB);
      if (state_q == S_WB) begin
        controle_q <= dest_q;
        entrada_q  <= result;
      end
    end
  end

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.wr       = wr_q;
  assign bus.controle = controle_q;
  assign bus.entrada  = entrada_q;
  assign dbg_state    = state_q;

endmodule
